// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: forward/PC encodings, controller FSM states,
// and the register-port structs used by the forward selectors.
package pipeline_ctrl_pkg;

  localparam int FWD_WIDTH  = 2;
  localparam int NUM_STAGES = 5;
  localparam int NUM_RS     = 2;

  localparam logic [FWD_WIDTH-1:0] FWD_NONE = 2'b00;
  localparam logic [FWD_WIDTH-1:0] FWD_MEM  = 2'b01;
  localparam logic [FWD_WIDTH-1:0] FWD_WB   = 2'b10;

  localparam logic [3:0] PC_BOOT   = 4'd0;
  localparam logic [3:0] PC_JUMP   = 4'd1;
  localparam logic [3:0] PC_BRANCH = 4'd2;

  localparam int ST_IF = 0;
  localparam int ST_ID = 1;
  localparam int ST_EX = 2;
  localparam int ST_ME = 3;
  localparam int ST_WB = 4;

  typedef enum logic [1:0] {BOOT, RUN, EX_WAIT, MEM_WAIT} ctrl_state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic       used;
  } rs_req_t;

  typedef struct packed {
    logic [4:0] addr;
    logic       we;
  } wr_port_t;

  // x0 never carries a produced value, so it can never be a forward source.
  function automatic logic rs_hit(rs_req_t rs, wr_port_t wp);
    return rs.used && (rs.addr != 5'd0) && wp.we && (wp.addr == rs.addr);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational EX operand forward select for one source register.
module fwd_unit
  import pipeline_ctrl_pkg::*;
(
  input  rs_req_t                rs,
  input  wr_port_t               wr_m,
  input  wr_port_t               wr_w,
  input  logic                   load_m,
  output logic [FWD_WIDTH-1:0]   fwd
);

  // A load's data is not available in MEM, so it can only be taken from WB.
  always_comb begin
    fwd = FWD_NONE;
    if (rs_hit(rs, wr_m) && !load_m) fwd = FWD_MEM;
    else if (rs_hit(rs, wr_w))       fwd = FWD_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stage
// stall/clear, EX forwarding, PC redirect, MEM wait timeout and perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 CPU_CLK,
  input  logic                 CPU_RST,
  input  logic                 jump_decision_i,
  input  logic                 branch_decision_i,
  input  logic [4:0]           rs1_raddr_i,
  input  logic [4:0]           rs2_raddr_i,
  input  logic                 rs1_used_i,
  input  logic                 rs2_used_i,
  input  logic                 ex_busy_i,
  input  logic                 mem_req_i,
  input  logic                 mem_we_i,
  input  logic                 dmem_ready_i,
  input  logic [4:0]           regfile_waddr_m_i,
  input  logic                 regfile_we_m_i,
  input  logic [4:0]           regfile_waddr_w_i,
  input  logic                 regfile_we_w_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 stall_ex_o,
  output logic                 stall_me_o,
  output logic                 stall_wb_o,
  output logic                 clear_if_o,
  output logic                 clear_id_o,
  output logic                 clear_ex_o,
  output logic                 clear_me_o,
  output logic                 clear_wb_o,
  output logic [1:0]           rs1_forward_o,
  output logic [1:0]           rs2_forward_o,
  output logic                 pc_set_o,
  output logic [3:0]           pc_mux_o,
  output logic                 mem_timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  ctrl_state_e state, state_nxt;
  logic [TW-1:0] wait_cnt, wait_cnt_nxt;
  logic timeout_hit;

  logic load_m, mem_hold, ex_hold, load_use, advance, br_take, jmp_take;
  logic [NUM_STAGES-1:0] stall_v, clear_v;
  logic pc_set;
  logic [3:0] pc_mux;

  rs_req_t  [NUM_RS-1:0]                rs;
  wr_port_t                             wr_m, wr_w;
  logic     [NUM_RS-1:0][FWD_WIDTH-1:0] fwd_sel;
  logic     [NUM_RS-1:0]                lu_hit;

  assign load_m = mem_req_i & ~mem_we_i;
  assign rs[0]  = {rs1_raddr_i, rs1_used_i};
  assign rs[1]  = {rs2_raddr_i, rs2_used_i};
  assign wr_m   = {regfile_waddr_m_i, regfile_we_m_i};
  assign wr_w   = {regfile_waddr_w_i, regfile_we_w_i};

  for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
    fwd_unit u_fwd (
      .rs     (rs[g]),
      .wr_m   (wr_m),
      .wr_w   (wr_w),
      .load_m (load_m),
      .fwd    (fwd_sel[g])
    );
    assign lu_hit[g] = rs[g].used & wr_m.we & (wr_m.addr == rs[g].addr);
  end

  // Holds are evaluated from the live handshake so the cycle that first sees
  // a pending MEM access or busy EX unit already freezes the affected stages.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
    mem_hold     = 1'b0;
    ex_hold      = 1'b0;
    load_use     = 1'b0;
    advance      = 1'b0;
    br_take      = 1'b0;
    jmp_take     = 1'b0;
    stall_v      = '0;
    clear_v      = '0;
    pc_set       = 1'b0;
    pc_mux       = PC_BOOT;

    if (state == BOOT) begin
      pc_set                = 1'b1;
      clear_v[ST_ME:ST_IF]  = '1;
      state_nxt             = RUN;
    end else begin
      mem_hold = (state == MEM_WAIT) ? ~dmem_ready_i : (mem_req_i & ~dmem_ready_i);
      ex_hold  = ~mem_hold & ex_busy_i;
      load_use = ~mem_hold & ~ex_hold & (state == RUN) & load_m & (|lu_hit);
      advance  = ~mem_hold & ~ex_hold & ~load_use;
      br_take  = advance & branch_decision_i;
      jmp_take = advance & ~branch_decision_i & jump_decision_i;

      if (mem_hold) begin
        stall_v[ST_ME:ST_IF] = '1;
        clear_v[ST_WB]       = 1'b1;
      end
      if (ex_hold || load_use) begin
        stall_v[ST_ID:ST_IF] = '1;
        clear_v[ST_EX]       = 1'b1;
      end
      if (br_take) begin
        pc_set         = 1'b1;
        pc_mux         = PC_BRANCH;
        clear_v[ST_IF] = 1'b1;
        clear_v[ST_ID] = 1'b1;
      end
      if (jmp_take) begin
        pc_set         = 1'b1;
        pc_mux         = PC_JUMP;
        clear_v[ST_IF] = 1'b1;
      end

      if (state == MEM_WAIT) begin
        wait_cnt_nxt = wait_cnt + TW'(1);
        if (dmem_ready_i) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = RUN;
          timeout_hit = 1'b1;
        end
      end else if (mem_hold) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = '0;
      end else begin
        state_nxt = ex_busy_i ? EX_WAIT : RUN;
      end
    end

    if (CPU_RST) begin
      stall_v = '0;
      clear_v = '0;
      pc_set  = 1'b0;
      pc_mux  = PC_BOOT;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      state         <= BOOT;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
      cycle_cnt_o   <= '0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      cycle_cnt_o <= cycle_cnt_o + CNT_WIDTH'(1);
      if (stall_v[ST_IF])       stall_cnt_o   <= stall_cnt_o + CNT_WIDTH'(1);
      if (br_take || jmp_take)  flush_cnt_o   <= flush_cnt_o + CNT_WIDTH'(1);
      if (timeout_hit)          mem_timeout_o <= 1'b1;
    end
  end

  assign {stall_wb_o, stall_me_o, stall_ex_o, stall_id_o, stall_if_o} = stall_v;
  assign {clear_wb_o, clear_me_o, clear_ex_o, clear_id_o, clear_if_o} = clear_v;
  assign rs1_forward_o = CPU_RST ? FWD_NONE : fwd_sel[0];
  assign rs2_forward_o = CPU_RST ? FWD_NONE : fwd_sel[1];
  assign pc_set_o      = pc_set;
  assign pc_mux_o      = pc_mux;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios followed by
// random traffic, checked against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int MT = 4;
  localparam int CW = 8;

  logic CPU_CLK = 1'b0;
  logic CPU_RST = 1'b1;
  logic jump_decision_i = 0, branch_decision_i = 0;
  logic [4:0] rs1_raddr_i = 0, rs2_raddr_i = 0;
  logic rs1_used_i = 0, rs2_used_i = 0, ex_busy_i = 0;
  logic mem_req_i = 0, mem_we_i = 0, dmem_ready_i = 1;
  logic [4:0] regfile_waddr_m_i = 0, regfile_waddr_w_i = 0;
  logic regfile_we_m_i = 0, regfile_we_w_i = 0;
  logic stall_if_o, stall_id_o, stall_ex_o, stall_me_o, stall_wb_o;
  logic clear_if_o, clear_id_o, clear_ex_o, clear_me_o, clear_wb_o;
  logic [1:0] rs1_forward_o, rs2_forward_o;
  logic pc_set_o, mem_timeout_o;
  logic [3:0] pc_mux_o;
  logic [CW-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .jump_decision_i(jump_decision_i), .branch_decision_i(branch_decision_i),
    .rs1_raddr_i(rs1_raddr_i), .rs2_raddr_i(rs2_raddr_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .ex_busy_i(ex_busy_i),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .dmem_ready_i(dmem_ready_i),
    .regfile_waddr_m_i(regfile_waddr_m_i), .regfile_we_m_i(regfile_we_m_i),
    .regfile_waddr_w_i(regfile_waddr_w_i), .regfile_we_w_i(regfile_we_w_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .stall_me_o(stall_me_o), .stall_wb_o(stall_wb_o),
    .clear_if_o(clear_if_o), .clear_id_o(clear_id_o), .clear_ex_o(clear_ex_o),
    .clear_me_o(clear_me_o), .clear_wb_o(clear_wb_o),
    .rs1_forward_o(rs1_forward_o), .rs2_forward_o(rs2_forward_o),
    .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o), .mem_timeout_o(mem_timeout_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  typedef struct {
    bit rst, jmp, br, u1, u2, busy, mreq, mwe, rdy, wem, wew;
    int rs1, rs2, wm, ww;
  } stim_t;

  typedef struct {
    int stall, clear, f1, f2, pcs, mux, to, cyc, stl, fl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: one flag per pipeline situation plus plain cycle counts.
  bit m_boot = 1, m_memw = 0, m_exw = 0, m_to = 0;
  int m_waited = 0, m_cyc = 0, m_stl = 0, m_fl = 0;

  function automatic int fwd_of(int r, bit used, stim_t s);
    bit ld = s.mreq && !s.mwe;
    if (!used || r == 0) return 0;
    if (s.wem && s.wm == r && !ld) return 1;
    if (s.wew && s.ww == r) return 2;
    return 0;
  endfunction

  function automatic stim_t idle();
    stim_t s = '{default: 0};
    s.rdy = 1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst  = 0;
    s.jmp  = ($urandom_range(0, 4) == 0);
    s.br   = ($urandom_range(0, 4) == 0);
    s.rs1  = $urandom_range(0, 3);
    s.rs2  = $urandom_range(0, 3);
    s.u1   = $urandom_range(0, 1);
    s.u2   = $urandom_range(0, 1);
    s.busy = ($urandom_range(0, 7) == 0);
    s.mreq = ($urandom_range(0, 3) == 0);
    s.mwe  = $urandom_range(0, 1);
    s.rdy  = ($urandom_range(0, 9) < 7);
    s.wm   = $urandom_range(0, 3);
    s.wem  = $urandom_range(0, 1);
    s.ww   = $urandom_range(0, 3);
    s.wew  = $urandom_range(0, 1);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e = '{default: 0};
    bit mh, eh, lu, adv, br, jp, ld;
    @(posedge CPU_CLK);
    #1;
    CPU_RST = s.rst; jump_decision_i = s.jmp; branch_decision_i = s.br;
    rs1_raddr_i = 5'(s.rs1); rs2_raddr_i = 5'(s.rs2);
    rs1_used_i = s.u1; rs2_used_i = s.u2; ex_busy_i = s.busy;
    mem_req_i = s.mreq; mem_we_i = s.mwe; dmem_ready_i = s.rdy;
    regfile_waddr_m_i = 5'(s.wm); regfile_we_m_i = s.wem;
    regfile_waddr_w_i = 5'(s.ww); regfile_we_w_i = s.wew;

    e.to  = m_to;
    e.cyc = m_cyc % (1 << CW);
    e.stl = m_stl % (1 << CW);
    e.fl  = m_fl % (1 << CW);
    mh = 0; eh = 0; lu = 0; br = 0; jp = 0;
    if (!s.rst) begin
      e.f1 = fwd_of(s.rs1, s.u1, s);
      e.f2 = fwd_of(s.rs2, s.u2, s);
      if (m_boot) begin
        e.pcs   = 1;
        e.clear = 5'b01111;
      end else begin
        ld  = s.mreq && !s.mwe;
        mh  = m_memw ? !s.rdy : (s.mreq && !s.rdy);
        eh  = !mh && s.busy;
        lu  = !mh && !eh && !m_memw && !m_exw && ld && s.wem &&
              ((s.u1 && s.rs1 == s.wm) || (s.u2 && s.rs2 == s.wm));
        adv = !mh && !eh && !lu;
        br  = adv && s.br;
        jp  = adv && !s.br && s.jmp;
        e.stall = {1'b0, mh, mh, mh | eh | lu, mh | eh | lu};
        e.clear = {mh, 1'b0, eh | lu, br, br | jp};
        e.pcs   = br | jp;
        e.mux   = br ? 2 : (jp ? 1 : 0);
      end
    end
    sb.push_back(e);

    if (s.rst) begin
      m_boot = 1; m_memw = 0; m_exw = 0; m_to = 0;
      m_waited = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      m_cyc++;
      if (mh || eh || lu) m_stl++;
      if (br || jp) m_fl++;
      if (m_boot) begin
        m_boot = 0;
      end else if (m_memw) begin
        m_waited++;
        if (s.rdy) m_memw = 0;
        else if (m_waited == MT) begin m_memw = 0; m_to = 1; end
      end else if (s.mreq && !s.rdy) begin
        m_memw = 1; m_waited = 0; m_exw = 0;
      end else begin
        m_exw = s.busy;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CPU_CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", int'({stall_wb_o, stall_me_o, stall_ex_o, stall_id_o, stall_if_o}), e.stall);
        chk("clear", int'({clear_wb_o, clear_me_o, clear_ex_o, clear_id_o, clear_if_o}), e.clear);
        chk("rs1_fwd", int'(rs1_forward_o), e.f1);
        chk("rs2_fwd", int'(rs2_forward_o), e.f2);
        chk("pc_set", int'(pc_set_o), e.pcs);
        chk("pc_mux", int'(pc_mux_o), e.mux);
        chk("mem_timeout", int'(mem_timeout_o), e.to);
        chk("cycle_cnt", int'(cycle_cnt_o), e.cyc);
        chk("stall_cnt", int'(stall_cnt_o), e.stl);
        chk("flush_cnt", int'(flush_cnt_o), e.fl);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    s = idle(); s.rst = 1;
    repeat (3) step(s);
    repeat (3) step(idle());

    // Forwarding: MEM producer, WB-only producer, x0 never forwarded.
    s = idle(); s.rs1 = 5; s.u1 = 1; s.wm = 5; s.wem = 1; step(s);
    s = idle(); s.rs1 = 5; s.u1 = 1; s.ww = 5; s.wew = 1; step(s);
    s = idle(); s.wm = 0; s.wem = 1; s.ww = 0; s.wew = 1; s.u1 = 1; s.u2 = 1; step(s);

    // Load-use then WB forward; branch ignored during the load-use bubble.
    s = idle(); s.mreq = 1; s.wm = 7; s.wem = 1; s.rs2 = 7; s.u2 = 1; s.br = 1; step(s);
    s = idle(); s.ww = 7; s.wew = 1; s.rs2 = 7; s.u2 = 1; step(s);

    // Branch and jump together: branch wins.
    s = idle(); s.br = 1; s.jmp = 1; step(s);
    s = idle(); s.jmp = 1; step(s);

    // Multi-cycle EX for four cycles.
    s = idle(); s.busy = 1; s.br = 1;
    repeat (4) step(s);
    step(idle());

    // Data memory never answers: timeout, sticky flag.
    s = idle(); s.mreq = 1; s.rdy = 0;
    repeat (5) step(s);
    repeat (2) step(idle());
    s = idle(); s.mreq = 1; s.rdy = 0;
    repeat (2) step(s);
    s.rdy = 1; step(s);

    repeat (400) step(rnd());

    s = idle(); s.rst = 1;
    repeat (2) step(s);
    repeat (120) step(rnd());

    @(negedge CPU_CLK);
    @(negedge CPU_CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage stall/clear, EX operand forward selects and the PC redirect (pc_set/pc_mux).
- Runs a small FSM for boot redirect, multi-cycle EX operations and data-memory wait with timeout.
- Keeps cycle, stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive cycles dmem_ready_i may stay low before the MEM wait is abandoned.
CNT_WIDTH, 32, width of each performance counter.

Ports:
CPU_CLK  in  1  clock; all state updates on rising edge
CPU_RST  in  1  synchronous, active-high reset
jump_decision_i  in  1  jump resolved in ID
branch_decision_i  in  1  taken branch resolved in EX
rs1_raddr_i  in  5  EX-stage rs1 index
rs2_raddr_i  in  5  EX-stage rs2 index
rs1_used_i  in  1  EX instruction reads rs1
rs2_used_i  in  1  EX instruction reads rs2
ex_busy_i  in  1  multi-cycle EX unit not finished
mem_req_i  in  1  MEM-stage instruction accesses memory
mem_we_i  in  1  MEM-stage access is a store
dmem_ready_i  in  1  data memory completes the MEM access this cycle
regfile_waddr_m_i  in  5  MEM-stage destination
regfile_we_m_i  in  1  MEM-stage writes regfile
regfile_waddr_w_i  in  5  WB-stage destination
regfile_we_w_i  in  1  WB-stage writes regfile
stall_if_o, stall_id_o, stall_ex_o, stall_me_o, stall_wb_o  out  1 each  hold the stage's output register
clear_if_o, clear_id_o, clear_ex_o, clear_me_o, clear_wb_o  out  1 each  load a bubble into the stage's output register; clear wins over stall
rs1_forward_o  out  2  FWD_NONE=00, FWD_MEM=01, FWD_WB=10
rs2_forward_o  out  2  same encoding
pc_set_o  out  1  redirect PC this cycle; overrides clear_if on the PC
pc_mux_o  out  4  PC_BOOT=0, PC_JUMP=1, PC_BRANCH=2
mem_timeout_o  out  1  sticky; set on MEM wait timeout
cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each  performance counters

Behaviour:
- Reset state:
  - FSM = BOOT; all counters 0; mem_timeout_o = 0.
  - While CPU_RST is high, all stall/clear outputs = 0 and forward selects = 00.
- FSM states: BOOT, RUN, EX_WAIT, MEM_WAIT.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - Outputs pc_set=1, pc_mux=PC_BOOT, clear_if=clear_id=clear_ex=clear_me=1.
  - Next state is RUN.
- Derived signal: load_m = mem_req_i & ~mem_we_i.
- Forwarding (combinational, evaluated per rs; rs1 shown):
  - FWD_MEM if rs1_used & rs1≠0 & we_m & waddr_m==rs1 & ~load_m.
  - Else FWD_WB if rs1_used & rs1≠0 & we_w & waddr_w==rs1.
  - Else FWD_NONE.
- Load-use (RUN only):
  - Trigger: load_m and a used rs matches waddr_m with we_m.
  - Actions: stall_if, stall_id, clear_ex for exactly one cycle.
  - Next cycle forwards from WB. No FSM state change.
- RUN to MEM_WAIT:
  - Trigger: mem_req_i & ~dmem_ready_i.
  - Each MEM_WAIT cycle: stall_if/id/ex/me=1, clear_wb=1.
  - Return to RUN the cycle dmem_ready_i=1.
  - A 0-based wait counter reaching MEM_TIMEOUT-1 also returns to RUN and sets mem_timeout_o.
- RUN to EX_WAIT:
  - Trigger: ex_busy_i (evaluated only when no MEM wait is pending).
  - Each EX_WAIT cycle: stall_if/id=1, clear_ex=1.
  - Exit to RUN on the first cycle with ex_busy_i=0.
  - A MEM wait arising during EX_WAIT moves the FSM to MEM_WAIT.
- Priority: reset > BOOT > MEM wait > EX wait > load-use > branch > jump.
- Branch flush:
  - Condition: branch_decision_i while EX advances (no EX wait, no load-use, no MEM wait).
  - Actions: pc_set=1, pc_mux=PC_BRANCH, clear_if=clear_id=1.
  - A simultaneous jump is discarded.
  - branch_decision_i is ignored while EX is held.
- Jump flush:
  - Condition: jump_decision_i with ID advancing and no branch.
  - Actions: pc_set=1, pc_mux=PC_JUMP, clear_if=1.
- Counters:
  - cycle_cnt increments every non-reset cycle.
  - stall_cnt increments on any cycle with stall_if=1.
  - flush_cnt increments on each branch/jump pc_set.
  - All counters wrap modulo 2^CNT_WIDTH.
- mem_timeout_o clears only on reset.

Decomposition:
- Shared core_pkg additions:
  - Forward encodings FWD_NONE/FWD_MEM/FWD_WB.
  - PC_BOOT/PC_JUMP/PC_BRANCH.
  - ctrl_state_e enum {BOOT, RUN, EX_WAIT, MEM_WAIT}.
  - FWD_WIDTH=2.
- One sub-module, fwd_unit: purely combinational forward select, instantiated once per rs.

Test Plan:
- Reset release: cycle 1 shows pc_set=1, pc_mux=0, clear_if..me=1; cycle 2 shows state RUN with all stall/clear 0.
- add x5 in MEM, EX rs1=5 used → rs1_forward=01; same with x5 in WB only → 10; rs1=0 with x0 matches → 00.
- lw x7 in MEM, EX rs2=7 used → one cycle stall_if=stall_id=clear_ex=1, then rs2_forward=10, stall_cnt=1.
- branch_decision=1 and jump_decision=1 in the same cycle → pc_mux=2, clear_if=clear_id=1, flush_cnt+1; branch during load-use cycle → no pc_set.
- ex_busy high 4 cycles → 4 cycles clear_ex=1/stall_id=1, exit on first low cycle.
- MEM_TIMEOUT=4, dmem_ready stuck 0 → 4 MEM_WAIT cycles, mem_timeout_o=1 and stays 1 until CPU_RST.
